// File: rtl/sar_logic_param.sv
// Parametrised successive-approximation controller: sample window, MSB-first
// binary search against the DAC, start/abort control and continuous restart.
module sar_logic_param #(
  parameter int WIDTH         = 12,
  parameter int SAMPLE_CYCLES = 2,
  parameter bit COMP_INVERT   = 1'b0
) (
  input  logic             clk_src,
  input  logic             reset_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             digital_in,
  output logic             sample,
  output logic             busy,
  output logic [WIDTH-1:0] da_converter,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             done
);

  localparam int KW = $clog2(WIDTH);
  localparam int CW = 4;
  localparam logic [WIDTH-1:0] MSB_ONLY    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [KW-1:0]    K_TOP       = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [KW-1:0]    r_k, w_k_nxt;
  logic [WIDTH-1:0] r_dac, w_dac_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic [WIDTH-1:0] w_trial;
  logic             r_sample, w_sample_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_done, w_done_nxt;
  logic             w_comp, w_go, w_sample_last, w_k_zero, w_finish;

  assign w_comp        = digital_in ^ COMP_INVERT;
  assign w_go          = (start | continuous) & ~abort;
  assign w_sample_last = (r_cnt == SAMPLE_LAST);
  assign w_k_zero      = (r_k == {KW{1'b0}});
  assign w_finish      = (r_state == S_CONVERT) & w_k_zero & ~abort;

  // Current bit takes the comparator decision; the next lower bit becomes the new trial.
  always_comb begin
    w_trial = r_dac;
    if (w_k_zero) begin
      w_trial[0] = w_comp;
    end else begin
      w_trial[r_k]          = w_comp;
      w_trial[r_k - KW'(1)] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:    w_state_nxt = w_go ? S_SAMPLE : S_IDLE;
      S_SAMPLE:  begin
        if (abort)              w_state_nxt = S_IDLE;
        else if (w_sample_last) w_state_nxt = S_CONVERT;
        else                    w_state_nxt = S_SAMPLE;
      end
      S_CONVERT: begin
        if (abort)         w_state_nxt = S_IDLE;
        else if (w_k_zero) w_state_nxt = S_DONE;
        else               w_state_nxt = S_CONVERT;
      end
      S_DONE:    w_state_nxt = w_go ? S_SAMPLE : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = {CW{1'b0}};
    w_k_nxt   = r_k;
    w_dac_nxt = {WIDTH{1'b0}};
    case (r_state)
      S_SAMPLE: begin
        if (abort) begin
          w_cnt_nxt = {CW{1'b0}};
        end else if (w_sample_last) begin
          w_dac_nxt = MSB_ONLY;
          w_k_nxt   = K_TOP;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_CONVERT: begin
        if (abort) begin
          w_dac_nxt = {WIDTH{1'b0}};
        end else if (w_k_zero) begin
          w_dac_nxt = w_trial;
        end else begin
          w_dac_nxt = w_trial;
          w_k_nxt   = r_k - KW'(1);
        end
      end
      default: w_dac_nxt = {WIDTH{1'b0}};
    endcase
    w_sample_nxt = (w_state_nxt == S_SAMPLE);
    w_busy_nxt   = (w_state_nxt == S_SAMPLE) || (w_state_nxt == S_CONVERT);
    w_done_nxt   = w_finish;
    w_valid_nxt  = r_valid | w_finish;
    w_result_nxt = w_finish ? w_trial : r_result;
  end

  always_ff @(posedge clk_src or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_k      <= {KW{1'b0}};
      r_dac    <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_sample <= 1'b0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_k      <= w_k_nxt;
      r_dac    <= w_dac_nxt;
      r_result <= w_result_nxt;
      r_sample <= w_sample_nxt;
      r_busy   <= w_busy_nxt;
      r_valid  <= w_valid_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign sample       = r_sample;
  assign busy         = r_busy;
  assign da_converter = r_dac;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign done         = r_done;

endmodule

// File: tb/tb_sar_logic_param.sv
// Bench for sar_logic_param: a 12-bit default instance and an 8-bit inverted-comparator
// instance, both checked every cycle against a conversion-timeline model.
module tb_sar_logic_param;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 1'b0, a_cont = 1'b0, a_abort = 1'b0;
  logic [11:0] a_vin = 12'h000;
  logic        a_din, a_sample, a_busy, a_valid, a_done;
  logic [11:0] a_dac, a_result;

  logic        b_start = 1'b0, b_cont = 1'b0, b_abort = 1'b0;
  logic [7:0]  b_vin = 8'h00;
  logic        b_din, b_sample, b_busy, b_valid, b_done;
  logic [7:0]  b_dac, b_result;

  // Ideal comparators; the B instance sees an active-low comparator.
  assign a_din = (a_vin >= a_dac);
  assign b_din = ~(b_vin >= b_dac);

  sar_logic_param u_a (
    .clk_src(clk), .reset_n(rst_n), .start(a_start), .continuous(a_cont),
    .abort(a_abort), .digital_in(a_din), .sample(a_sample), .busy(a_busy),
    .da_converter(a_dac), .result(a_result), .result_valid(a_valid), .done(a_done)
  );

  sar_logic_param #(.WIDTH(8), .SAMPLE_CYCLES(4), .COMP_INVERT(1'b1)) u_b (
    .clk_src(clk), .reset_n(rst_n), .start(b_start), .continuous(b_cont),
    .abort(b_abort), .digital_in(b_din), .sample(b_sample), .busy(b_busy),
    .da_converter(b_dac), .result(b_result), .result_valid(b_valid), .done(b_done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  int tr[16];

  // Model: a conversion is a timeline of SC sample cycles, W binary-search steps, one done cycle.
  bit m_act[2];
  int m_p[2];
  int m_vin[2];
  int m_res[2];
  bit m_valid[2];

  function automatic int wid(input int id);
    return (id == 0) ? 12 : 8;
  endfunction

  function automatic int scn(input int id);
    return (id == 0) ? 2 : 4;
  endfunction

  task automatic model_step(input int id, input logic st, input logic co, input logic ab, input int vin);
    int last;
    last = scn(id) + wid(id);
    if (m_act[id] && m_p[id] < last) begin
      if (ab) begin
        m_act[id] = 1'b0;
      end else begin
        m_p[id]++;
        if (m_p[id] == last) begin
          m_res[id]   = m_vin[id];
          m_valid[id] = 1'b1;
        end
      end
    end else if ((st || co) && !ab) begin
      m_act[id] = 1'b1;
      m_p[id]   = 0;
      m_vin[id] = vin;
    end else begin
      m_act[id] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 1'b0; m_p[i] = 0; m_vin[i] = 0; m_res[i] = 0; m_valid[i] = 1'b0;
      end
    end else begin
      model_step(0, a_start, a_cont, a_abort, int'(a_vin));
      model_step(1, b_start, b_cont, b_abort, int'(b_vin));
    end
  end

  function automatic int exp_dac(input int id);
    int w, s, j;
    w = wid(id);
    s = scn(id);
    if (!m_act[id] || m_p[id] < s) return 0;
    if (m_p[id] < s + w) begin
      j = m_p[id] - s;
      return ((m_vin[id] >> (w - j)) << (w - j)) | (1 << (w - 1 - j));
    end
    return m_vin[id];
  endfunction

  function automatic int exp_sample(input int id);
    return (m_act[id] && m_p[id] < scn(id)) ? 1 : 0;
  endfunction

  function automatic int exp_busy(input int id);
    return (m_act[id] && m_p[id] < scn(id) + wid(id)) ? 1 : 0;
  endfunction

  function automatic int exp_done(input int id);
    return (m_act[id] && m_p[id] == scn(id) + wid(id)) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("a_sample", 32'(a_sample), exp_sample(0));
        chk("a_busy",   32'(a_busy),   exp_busy(0));
        chk("a_dac",    32'(a_dac),    exp_dac(0));
        chk("a_done",   32'(a_done),   exp_done(0));
        chk("a_result", 32'(a_result), m_res[0]);
        chk("a_valid",  32'(a_valid),  32'(m_valid[0]));
        chk("b_sample", 32'(b_sample), exp_sample(1));
        chk("b_busy",   32'(b_busy),   exp_busy(1));
        chk("b_dac",    32'(b_dac),    exp_dac(1));
        chk("b_done",   32'(b_done),   exp_done(1));
        chk("b_result", 32'(b_result), m_res[1]);
        chk("b_valid",  32'(b_valid),  32'(m_valid[1]));
      end
    end
  endtask

  // Latency counts from the start edge to the edge at which done is first sampled high.
  task automatic conv(input int id, input logic [15:0] vin, output int lat, output int ns,
                      output logic [15:0] res);
    int t0;
    if (id == 0) begin a_vin = vin[11:0]; a_start = 1'b1; end
    else begin b_vin = vin[7:0]; b_start = 1'b1; end
    @(negedge clk);
    t0 = cyc;
    a_start = 1'b0;
    b_start = 1'b0;
    lat = -1;
    ns  = 0;
    res = 16'h0000;
    for (int i = 0; i < 60; i++) begin
      if (id == 0 && (cyc - t0) < 16) tr[cyc - t0] = 32'(a_dac);
      if ((id == 0) ? a_sample : b_sample) ns++;
      if ((id == 0) ? a_done : b_done) begin
        lat = cyc - t0 + 1;
        res = (id == 0) ? 16'(a_result) : 16'(b_result);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int id, output int c);
    c = -1;
    for (int i = 0; i < 60; i++) begin
      if ((id == 0) ? a_done : b_done) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, ns, d1, d2, ndone;
    logic [15:0] res;
    fork
      cmp_loop();
    join_none

    #12;
    chk("rst_sample", 32'(a_sample), 32'd0);
    chk("rst_busy",   32'(a_busy),   32'd0);
    chk("rst_dac",    32'(a_dac),    32'd0);
    chk("rst_result", 32'(a_result), 32'd0);
    chk("rst_valid",  32'(a_valid),  32'd0);
    chk("rst_done",   32'(a_done),   32'd0);
    #11 rst_n = 1'b1;
    @(negedge clk);

    // Single conversion of 0xA5C.
    conv(0, 16'h0A5C, lat, ns, res);
    chk("t1_result",  32'(res), 32'h0A5C);
    chk("t1_latency", lat, 32'd15);
    chk("t1_samples", ns, 32'd2);
    chk("t1_trial0",  tr[2], 32'h800);
    chk("t1_trial1",  tr[3], 32'hC00);
    chk("t1_trial2",  tr[4], 32'hA00);
    chk("t1_valid",   32'(a_valid), 32'd1);
    @(negedge clk);
    chk("t1_idle_busy", 32'(a_busy), 32'd0);
    chk("t1_idle_dac",  32'(a_dac),  32'd0);

    // Boundary codes.
    conv(0, 16'h0000, lat, ns, res);
    chk("t2_zero", 32'(res), 32'h000);
    conv(0, 16'h0FFF, lat, ns, res);
    chk("t2_full", 32'(res), 32'hFFF);
    chk("t2_full_latency", lat, 32'd15);
    repeat (2) @(negedge clk);
    chk("t2_idle_dac",  32'(a_dac),  32'd0);
    chk("t2_idle_busy", 32'(a_busy), 32'd0);

    // Continuous back-to-back conversions.
    a_vin  = 12'h123;
    a_cont = 1'b1;
    @(negedge clk);
    wait_done(0, d1);
    chk("t3_res1", 32'(a_result), 32'h123);
    a_vin = 12'h7FF;
    @(negedge clk);
    chk("t3_no_idle_sample", 32'(a_sample), 32'd1);
    chk("t3_no_idle_busy",   32'(a_busy),   32'd1);
    wait_done(0, d2);
    chk("t3_spacing", d2 - d1, 32'd15);
    chk("t3_res2", 32'(a_result), 32'h7FF);
    a_cont = 1'b0;
    @(negedge clk);
    chk("t3_stop_busy", 32'(a_busy), 32'd0);

    // Abort on the 6th convert cycle after a prior 0x555 result.
    conv(0, 16'h0555, lat, ns, res);
    chk("t4_prior", 32'(res), 32'h555);
    @(negedge clk);
    a_vin   = 12'h3A7;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("t4_trial5", 32'(a_dac), 32'h3C0);
    a_abort = 1'b1;
    @(negedge clk);
    chk("t4_busy",   32'(a_busy),   32'd0);
    chk("t4_sample", 32'(a_sample), 32'd0);
    chk("t4_dac",    32'(a_dac),    32'd0);
    chk("t4_result", 32'(a_result), 32'h555);
    chk("t4_valid",  32'(a_valid),  32'd1);
    a_abort = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_done) ndone++;
    end
    chk("t4_no_done", ndone, 32'd0);
    conv(0, 16'h03A7, lat, ns, res);
    chk("t4_after", 32'(res), 32'h3A7);

    // Asynchronous reset in the middle of the sample window.
    a_vin   = 12'h9C4;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("t5_in_sample", 32'(a_sample), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sample", 32'(a_sample), 32'd0);
    chk("t5_busy",   32'(a_busy),   32'd0);
    chk("t5_dac",    32'(a_dac),    32'd0);
    chk("t5_result", 32'(a_result), 32'd0);
    chk("t5_valid",  32'(a_valid),  32'd0);
    chk("t5_done",   32'(a_done),   32'd0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    conv(0, 16'h09C4, lat, ns, res);
    chk("t5_after", 32'(res), 32'h9C4);
    chk("t5_after_latency", lat, 32'd15);

    // 8-bit instance, 4 sample cycles, active-low comparator.
    conv(1, 16'h003C, lat, ns, res);
    chk("t6_result",  32'(res), 32'h3C);
    chk("t6_latency", lat, 32'd13);
    chk("t6_samples", ns, 32'd4);
    chk("t6_valid",   32'(b_valid), 32'd1);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
